ps2_rx_frontend: RTL
====================

// Module: ps2_rx_frontend
// PURPOSE
//  Receive-side front end for the PS/2 keyboard port, directly upstream of the PS/2 Wishbone peripheral.
//  - Synchronises and glitch-filters the raw PS/2 clock/data pins.
//  - Deframes 11-bit device-to-host frames and checks parity/stop.
//  - Buffers good scancodes in a first-word-fall-through FIFO that the peripheral pops, all in the system clock domain.
// PARAMETERS
//  CLK_FREQ    100000000  system clock in Hz
//  FILTER_LEN  8          consecutive equal samples needed to change the filtered PS/2 clock (2..16)
//  TIMEOUT_US  200        max gap between PS/2 clock falling edges inside a frame, in us
//  FIFO_AW     3          FIFO address width; depth = 2**FIFO_AW
// PORTS
//  clk          in   1        system clock
//  rst          in   1        asynchronous active-low reset (0 = reset)
//  ps2_clk_in   in   1        raw PS/2 clock pin, asynchronous
//  ps2_dat_in   in   1        raw PS/2 data pin, asynchronous
//  rd_en        in   1        pop FIFO head; ignored when empty
//  code_o       out  8        FIFO head scancode (valid when valid_o = 1)
//  valid_o      out  1        FIFO not empty
//  count_o      out  FIFO_AW+1  FIFO occupancy
//  brk_o        out  1        head entry is a key release (see CONFIGURATION)
//  ext_o        out  1        head entry is an E0-extended key (see CONFIGURATION)
//  frame_err_o  out  1        sticky: parity, stop-bit or timeout error
//  overflow_o   out  1        sticky: frame dropped because FIFO was full
//  clr_err      in   1        synchronous clear of both sticky flags
// BEHAVIOUR
//  - Reset: every output is 0, FIFO is empty, FSM is in IDLE, filtered clock is 1, synchroniser flops are 1.
//  - Input path: a 2-FF synchroniser on each pin feeds the filter.
//    - Filtered clock goes 0 after FILTER_LEN consecutive synced 0s, and goes 1 after FILTER_LEN consecutive 1s.
//    - fall = 1-cycle pulse on the filtered 1->0 transition.
//    - Data is sampled from the synced data pin in the cycle of fall.
//  - FSM (advances only on fall, except on timeout):
//    - IDLE:   data=0 -> DATA with bit_cnt=0; data=1 -> stay in IDLE (spurious edge).
//    - DATA:   shift data in LSB first; after the 8th bit -> PARITY.
//    - PARITY: sample the parity bit; ok = odd parity over the 8 data bits plus the parity bit; -> STOP.
//    - STOP:   -> IDLE. If stop=1 and ok, push the byte; otherwise set frame_err_o and push nothing.
//  - Timeout: a cycle counter clears on every fall and counts while the FSM is not in IDLE.
//    - At CLK_FREQ/1000000*TIMEOUT_US cycles (20000 at defaults): FSM -> IDLE, frame_err_o set, partial byte discarded.
//  - FIFO:
//    - Push and pop each take 1 cycle; pointers wrap modulo the depth.
//    - code_o/brk_o/ext_o show the head combinationally from registered storage.
//    - After a push into an empty FIFO, valid_o rises in the following cycle.
//    - Pop is evaluated before push: push while full with rd_en=1 is accepted and the count is unchanged.
//    - Push while full with no pop: frame dropped, overflow_o set, FIFO contents unchanged.
//    - rd_en while empty: no effect; the count never underflows.
//  - clr_err in the same cycle as a new error: the error wins and the flag stays 1.
//  - Reset asserted mid-frame: immediate return to reset state; the partial frame is lost.
// CONFIGURATION
//  - PS2_BREAK_DECODE_EN defined:
//    - Prefix bytes F0 and E0 are not pushed; they set pending brk/ext bits.
//    - The next non-prefix byte is pushed together with {ext,brk}, and the pending bits then clear.
//    - A frame error clears the pending bits.
//  - Not defined: every good byte is pushed raw, including F0/E0, and brk_o = ext_o = 0.
// STRUCTURE
//  - ps2_pkg.vh holds the FSM state encodings (IDLE, DATA, PARITY, STOP) and the constants PS2_BRK_CODE=8'hF0 and PS2_EXT_CODE=8'hE0.
//  - Sub-module ps2_sync_filter: the synchroniser, clock glitch filter and fall pulse (outputs clk_f, dat_s, fall).
//  - FSM, timeout and FIFO stay in ps2_rx_frontend.
// TESTING
//  1. Frame for code 8'h1C (start 0, data LSB first, parity 0, stop 1), PS/2 clock at 12.5 kHz
//     -> valid_o=1, code_o=1C, count_o=1; then rd_en for 1 cycle -> valid_o=0.
//  2. Same frame with parity 1 -> nothing pushed, frame_err_o=1; clr_err -> frame_err_o=0.
//  3. Start bit and 3 data bits, then clock held high 250 us -> frame_err_o=1, FSM in IDLE;
//     next good frame 8'h29 is received correctly.
//  4. 9 good frames with no pops (depth 8) -> count_o=8, overflow_o=1, head is the first code.
//     A 9th push in the same cycle as rd_en -> accepted, count_o stays 8.
//  5. 3-cycle glitches on ps2_clk_in during a frame -> no extra bits; code received intact.
//  6. With PS2_BREAK_DECODE_EN, frames E0,F0,75 -> one entry: code_o=75, brk_o=1, ext_o=1.
//     Without the macro -> 3 raw entries.

Source files
------------

// File: rtl/ps2_rx_frontend_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_rx_frontend_pkg
// Brief    : Shared types and constants for the PS/2 receive front end:
//            deframer state encoding, prefix scancodes, FIFO entry layout
//            and the frame parity helper.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_rx_frontend_pkg;

  // Deframer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Scancode prefixes: key release and extended key
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;

  // One FIFO entry: decoded flags plus the scancode itself
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_sync_filter
// Brief    : Two-flop synchronisers on the raw PS/2 clock and data pins,
//            a consecutive-sample glitch filter on the clock, and a one-cycle
//            pulse on each filtered falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_f,
  output logic dat_s,
  output logic fall
);

  localparam int                 c_cnt_w   = $clog2(FILTER_LEN);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_LEN - 1);

  logic [1:0]         r_clk_sync;
  logic [1:0]         r_dat_sync;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_clk_f;
  logic               r_fall;
  logic               w_differs;
  logic               w_flip;

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample
  assign w_differs = (r_clk_sync[1] != r_clk_f);
  assign w_flip    = w_differs && (r_cnt == c_cnt_max);

  // Two-flop synchronisers; idle bus level is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
      r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
    end
  end

  // Run-length glitch filter on the clock and falling-edge pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_clk_f <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      if (!w_differs || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_flip) begin
        r_clk_f <= ~r_clk_f;
      end
      r_fall <= w_flip && r_clk_f;
    end
  end

  assign clk_f = r_clk_f;
  assign dat_s = r_dat_sync[1];
  assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_rx_frontend
// Brief    : PS/2 device-to-host receive front end. Filters the pins,
//            deframes 11-bit frames with parity/stop/timeout checking and
//            queues good scancodes in a first-word-fall-through FIFO.
//            Optional macro PS2_BREAK_DECODE_EN folds F0/E0 prefixes into
//            brk/ext flags on the following scancode.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_frontend #(
  parameter int CLK_FREQ   = 100000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk_in,
  input  logic               ps2_dat_in,
  input  logic               rd_en,
  output logic [7:0]         code_o,
  output logic               valid_o,
  output logic [FIFO_AW:0]   count_o,
  output logic               brk_o,
  output logic               ext_o,
  output logic               frame_err_o,
  output logic               overflow_o,
  input  logic               clr_err
);

  import ps2_rx_frontend_pkg::*;

  localparam int                 c_timeout = CLK_FREQ / 1000000 * TIMEOUT_US;
  localparam int                 c_to_w    = $clog2(c_timeout + 1);
  localparam logic [c_to_w-1:0]  c_to_last = c_to_w'(c_timeout - 1);
  localparam int                 c_depth   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   c_full    = {1'b1, {FIFO_AW{1'b0}}};

  logic                w_clk_f;
  logic                w_dat;
  logic                w_fall_raw;
  logic                w_fall;

  ps2_state_t          r_state;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_par_ok;
  logic [c_to_w-1:0]   r_to_cnt;
  logic                r_push_vld;
  ps2_entry_t          r_push_ent;
  logic                r_frame_err;
  logic                r_overflow;
`ifdef PS2_BREAK_DECODE_EN
  logic                r_pend_brk;
  logic                r_pend_ext;
`endif

  ps2_entry_t          r_mem [c_depth];
  logic [FIFO_AW-1:0]  r_wr_ptr;
  logic [FIFO_AW-1:0]  r_rd_ptr;
  logic [FIFO_AW:0]    r_count;
  ps2_entry_t          w_head;

  logic                w_timeout;
  logic                w_stop_fall;
  logic                w_frame_good;
  logic                w_err_set;
  logic                w_pop;
  logic                w_full;
  logic                w_push_ok;
  logic                w_ovf_set;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_f      (w_clk_f),
    .dat_s      (w_dat),
    .fall       (w_fall_raw)
  );

  // A falling edge is only honoured while the filtered clock actually reads low
  assign w_fall       = w_fall_raw & ~w_clk_f;
  assign w_timeout    = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == c_to_last);
  assign w_stop_fall  = w_fall && (r_state == ST_STOP);
  assign w_frame_good = w_stop_fall && w_dat && r_par_ok;
  assign w_err_set    = w_timeout || (w_stop_fall && !(w_dat && r_par_ok));

  // Deframer: advances on filtered falling edges, aborts on inter-edge timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_ok   <= 1'b0;
      r_push_vld <= 1'b0;
      r_push_ent <= '0;
`ifdef PS2_BREAK_DECODE_EN
      r_pend_brk <= 1'b0;
      r_pend_ext <= 1'b0;
`endif
    end else begin
      r_push_vld <= 1'b0;
      if (w_timeout) begin
        r_state <= ST_IDLE;
`ifdef PS2_BREAK_DECODE_EN
        r_pend_brk <= 1'b0;
        r_pend_ext <= 1'b0;
`endif
      end else if (w_fall) begin
        unique case (r_state)
          ST_IDLE: begin
            // A high data line here is a spurious edge, not a start bit
            if (!w_dat) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_par_ok <= odd_parity_ok(r_shift, w_dat);
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
`ifdef PS2_BREAK_DECODE_EN
            if (w_frame_good) begin
              if (r_shift == PS2_BRK_CODE) begin
                r_pend_brk <= 1'b1;
              end else if (r_shift == PS2_EXT_CODE) begin
                r_pend_ext <= 1'b1;
              end else begin
                r_push_vld <= 1'b1;
                r_push_ent <= '{ext: r_pend_ext, brk: r_pend_brk, code: r_shift};
                r_pend_brk <= 1'b0;
                r_pend_ext <= 1'b0;
              end
            end else begin
              r_pend_brk <= 1'b0;
              r_pend_ext <= 1'b0;
            end
`else
            if (w_frame_good) begin
              r_push_vld <= 1'b1;
              r_push_ent <= '{ext: 1'b0, brk: 1'b0, code: r_shift};
            end
`endif
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Inter-edge gap counter, idle outside a frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_IDLE) || w_fall) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // FIFO control: pop is considered first, so a full FIFO accepts a push alongside a pop
  assign w_pop     = rd_en && (r_count != '0);
  assign w_full    = (r_count == c_full);
  assign w_push_ok = r_push_vld && (!w_full || w_pop);
  assign w_ovf_set = r_push_vld && w_full && !w_pop;

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_frame_err <= 1'b1;
      end else if (clr_err) begin
        r_frame_err <= 1'b0;
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_push_ent;
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign valid_o     = (r_count != '0);
  assign code_o      = valid_o ? w_head.code : 8'h00;
  assign brk_o       = valid_o & w_head.brk;
  assign ext_o       = valid_o & w_head.ext;
  assign count_o     = r_count;
  assign frame_err_o = r_frame_err;
  assign overflow_o  = r_overflow;

endmodule
`default_nettype wire
